deser8_rx: RTL and testbench

DESER8_RX -- requirements
Module: deser8_rx

---
 rtl/deser8_rx_if.sv | 25 ++
 rtl/deser8_rx.sv | 91 +++++++++
 tb/tb_deser8_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/deser8_rx_if.sv
// Bus bundle for deser8_rx: serial input handshake, parallel output handshake,
// clear strobe and status counters.
//   master : drives clr, sin_valid, sin, out_ready; observes the rest
//   slave  : the receiver; drives sin_ready, dout, dout_valid, bit_cnt, word_cnt
interface deser8_rx_if;
    logic       clr;
    logic       sin_valid;
    logic       sin;
    logic       sin_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       out_ready;
    logic [2:0] bit_cnt;
    logic [7:0] word_cnt;

    modport master (
        output clr, sin_valid, sin, out_ready,
        input  sin_ready, dout, dout_valid, bit_cnt, word_cnt
    );

    modport slave (
        input  clr, sin_valid, sin, out_ready,
        output sin_ready, dout, dout_valid, bit_cnt, word_cnt
    );
endinterface

// File: rtl/deser8_rx.sv
// 8-bit serial-to-parallel receiver with a one-word holding register.
// Bits 0..6 of the next frame are accepted while the holding word is still
// undelivered; only the 8th bit stalls until the consumer takes the word.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : deser8_rx_if.slave (clr, sin_valid/sin/sin_ready,
//              dout/dout_valid/out_ready, bit_cnt, word_cnt)
//   MSB_FIRST: 1 = first bit lands in dout[7], 0 = first bit lands in dout[0]
module deser8_rx #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    deser8_rx_if.slave   bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WCNT_W = 8;

    logic [DATA_W-1:0] shreg_q,      shreg_d;
    logic [DATA_W-1:0] dout_q,       dout_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q,   word_cnt_d;
    logic              dout_valid_q, dout_valid_d;
    logic              ready_q,      ready_d;
    logic              accept_c;
    logic [DATA_W-1:0] shifted_c;

    // Next-state logic; clear outranks both handshakes
    always_comb begin
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        dout_valid_d = dout_valid_q;
        accept_c     = bus.sin_valid && ready_q;
        shifted_c    = MSB_FIRST ? {shreg_q[DATA_W-2:0], bus.sin}
                                 : {bus.sin, shreg_q[DATA_W-1:1]};

        if (bus.clr) begin
            shreg_d      = '0;
            bit_cnt_d    = '0;
            dout_valid_d = 1'b0;
        end else begin
            if (dout_valid_q && bus.out_ready) begin
                dout_valid_d = 1'b0;
                word_cnt_d   = word_cnt_q + WCNT_W'(1);
            end
            // Accept at bit 7 only happens with the holding register empty,
            // so the load never collides with a delivery above
            if (accept_c) begin
                shreg_d = shifted_c;
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    dout_d       = shifted_c;
                    dout_valid_d = 1'b1;
                    bit_cnt_d    = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end

        // Ready is precomputed from next state so it leaves a flop
        ready_d = !((bit_cnt_d == CNT_W'(DATA_W - 1)) && dout_valid_d);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q      <= '0;
            dout_q       <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            dout_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            dout_valid_q <= dout_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.sin_ready  = ready_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.bit_cnt    = bit_cnt_q;
    assign bus.word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_deser8_rx.sv
// Bench for deser8_rx: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared every cycle against a frame-level model
// (queue of received bits, holding word, delivered-word count).
module tb_deser8_rx;
    logic clk;
    logic reset_n;
    logic clr;
    logic sin_valid;
    logic sin;
    logic out_ready;

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model state
    bit         frame_q[$];
    logic [7:0] m_dout_m;
    logic [7:0] m_dout_l;
    logic       m_valid;
    logic [7:0] m_wc;

    deser8_rx_if bus_m();
    deser8_rx_if bus_l();

    assign bus_m.clr       = clr;
    assign bus_m.sin_valid = sin_valid;
    assign bus_m.sin       = sin;
    assign bus_m.out_ready = out_ready;
    assign bus_l.clr       = clr;
    assign bus_l.sin_valid = sin_valid;
    assign bus_l.sin       = sin;
    assign bus_l.out_ready = out_ready;

    deser8_rx #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset_n(reset_n), .bus(bus_m.slave));
    deser8_rx #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset_n(reset_n), .bus(bus_l.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_dout_m = '0;
        m_dout_l = '0;
        m_valid  = 1'b0;
        m_wc     = '0;
    endtask

    // One clock edge of the receiver, described at frame level
    task automatic model_edge(input logic c, input logic v, input logic b, input logic r);
        bit rdy;
        rdy = !(frame_q.size() == 7 && m_valid);
        if (c) begin
            frame_q.delete();
            m_valid = 1'b0;
        end else begin
            if (m_valid && r) begin
                m_valid = 1'b0;
                m_wc    = m_wc + 8'd1;
            end
            if (v && rdy) begin
                frame_q.push_back(b);
                if (frame_q.size() == 8) begin
                    for (int i = 0; i < 8; i++) begin
                        m_dout_m[7-i] = frame_q[i];
                        m_dout_l[i]   = frame_q[i];
                    end
                    m_valid = 1'b1;
                    frame_q.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_rdy;
        exp_rdy = !(frame_q.size() == 7 && m_valid);
        check({tag, ".m.dout"},      bus_m.dout,       m_dout_m);
        check({tag, ".l.dout"},      bus_l.dout,       m_dout_l);
        check({tag, ".m.valid"},     bus_m.dout_valid, m_valid);
        check({tag, ".l.valid"},     bus_l.dout_valid, m_valid);
        check({tag, ".m.bit_cnt"},   bus_m.bit_cnt,    frame_q.size());
        check({tag, ".l.bit_cnt"},   bus_l.bit_cnt,    frame_q.size());
        check({tag, ".m.word_cnt"},  bus_m.word_cnt,   m_wc);
        check({tag, ".l.word_cnt"},  bus_l.word_cnt,   m_wc);
        check({tag, ".m.sin_ready"}, bus_m.sin_ready,  exp_rdy);
        check({tag, ".l.sin_ready"}, bus_l.sin_ready,  exp_rdy);
    endtask

    task automatic step(input string tag, input logic c, input logic v, input logic b, input logic r);
        @(negedge clk);
        clr       = c;
        sin_valid = v;
        sin       = b;
        out_ready = r;
        @(posedge clk);
        model_edge(c, v, b, r);
        #1;
        check_all(tag);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] first_to_last, input logic r);
        for (int i = 7; i >= 0; i--) step(tag, 1'b0, 1'b1, first_to_last[i], r);
    endtask

    initial begin
        logic [7:0] saved;
        logic [7:0] w2;
        logic [15:0] bs;

        n_checks  = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        clr       = 1'b0;
        sin_valid = 1'b0;
        sin       = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic receive: stream 1,0,1,0,0,1,0,1
        send_byte("basic", 8'b1010_0101, 1'b1);
        check("basic.m.a5", bus_m.dout, 8'hA5);
        check("basic.l.a5", bus_l.dout, 8'hA5);
        step("basic.dlv", 1'b0, 1'b0, 1'b0, 1'b1);
        check("basic.wc1", bus_m.word_cnt, 8'd1);

        // Bit order: stream 1,0,0,0,0,0,0,0
        send_byte("order", 8'b1000_0000, 1'b1);
        check("order.m.80", bus_m.dout, 8'h80);
        check("order.l.01", bus_l.dout, 8'h01);
        step("order.dlv", 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-pressure: 16 bits, consumer stalled, 16th bit must wait
        bs = 16'($urandom);
        for (int i = 15; i >= 1; i--) step("bp", 1'b0, 1'b1, bs[i], 1'b0);
        check("bp.m.stall", bus_m.sin_ready, 1'b0);
        check("bp.m.held", bus_m.dout, bs[15:8]);
        step("bp.hold", 1'b0, 1'b1, bs[0], 1'b0);
        step("bp.hold", 1'b0, 1'b1, bs[0], 1'b0);
        step("bp.take", 1'b0, 1'b1, bs[0], 1'b1);
        step("bp.load", 1'b0, 1'b1, bs[0], 1'b0);
        w2 = bs[7:0];
        check("bp.m.word2", bus_m.dout, w2);
        check("bp.valid2", bus_m.dout_valid, 1'b1);
        step("bp.dlv", 1'b0, 1'b0, 1'b0, 1'b1);

        // Clear at bit_cnt 4 with a word pending
        send_byte("clr", 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) step("clr", 1'b0, 1'b1, 1'($urandom), 1'b0);
        saved = bus_m.dout;
        step("clr.pulse", 1'b1, 1'b1, 1'b1, 1'b1);
        check("clr.bit_cnt", bus_m.bit_cnt, 3'd0);
        check("clr.valid", bus_m.dout_valid, 1'b0);
        check("clr.dout", bus_m.dout, saved);

        // Randomised traffic
        for (int i = 0; i < 1500; i++)
            step("rnd", 1'(($urandom % 64) == 0), 1'(($urandom % 4) != 0),
                 1'($urandom), 1'(($urandom % 3) != 0));

        // Async reset between edges, mid-frame
        for (int i = 0; i < 5; i++) step("ar", 1'b0, 1'b1, 1'($urandom), 1'b0);
        @(negedge clk);
        sin_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("ar.async");
        repeat (2) @(posedge clk);
        #1;
        check_all("ar.held");
        @(negedge clk);
        reset_n = 1'b1;
        send_byte("ar.frame", 8'h3C, 1'b1);
        check("ar.m.3c", bus_m.dout, 8'h3C);
        check("ar.l.3c", bus_l.dout, 8'h3C);

        // Word counter wrap: 256 deliveries after reset, then one more
        for (int w = 1; w < 256; w++) send_byte("wrap", 8'($urandom), 1'b1);
        step("wrap.dlv", 1'b0, 1'b0, 1'b0, 1'b1);
        check("wrap.zero", bus_m.word_cnt, 8'h00);
        send_byte("wrap.one", 8'($urandom), 1'b1);
        step("wrap.dlv1", 1'b0, 1'b0, 1'b0, 1'b1);
        check("wrap.one", bus_m.word_cnt, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
